// File: rtl/filter2d_hist.sv
// rtl/filter2d_hist.sv - per-frame 256-bin histogram of the filtered pixel stream

// Single-port bin storage: synchronous write, registered read data.
module mem_single #(
   parameter int AW = 8,
   parameter int DW = 17
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   // One access per cycle: either write din or register the addressed word.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= din;
         end else begin
            dout <= mem[addr];
         end
      end
   end

endmodule

module filter2d_hist #(
   parameter int NPIX = 65536
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic        i_strb,
   input  logic [7:0]  i_data,
   input  logic        h_clear,
   input  logic        r_req,
   input  logic [7:0]  r_bin,
   output logic        r_valid,
   output logic [16:0] r_data,
   output logic        o_ready,
   output logic        o_done,
   output logic        o_drop
);

   localparam logic [16:0] NPIX_CNT = 17'(NPIX);

   typedef enum logic [1:0] {S_CLR, S_ACC, S_RD} state_t;
   typedef enum logic [1:0] {RMW_IDLE, RMW_READ, RMW_WRITE} rmw_t;

   state_t      state;
   state_t      state_nx;
   rmw_t        rmw_stage;
   logic [7:0]  rmw_bin;
   logic [7:0]  clr_addr;
   logic [16:0] pix_cnt;
   logic        rd_pend;

   logic        mem_en;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [16:0] mem_din;
   logic [16:0] mem_dout;

   logic        strb_take;
   logic        strb_drop;
   logic        rmw_last;
   logic        rd_take;

   // A strobe is only taken in ACC with the RMW pipe idle; h_clear swallows
   // any strobe in the same cycle without flagging it as a drop.
   assign strb_take = (state == S_ACC) && i_strb && (rmw_stage == RMW_IDLE) && !h_clear;
   assign strb_drop = i_strb && !h_clear && !strb_take;
   assign rmw_last  = (rmw_stage == RMW_WRITE) && ((pix_cnt + 17'd1) == NPIX_CNT);
   assign rd_take   = (state == S_RD) && r_req && !h_clear;
   assign o_ready   = (state == S_ACC);

   mem_single #(.AW(8), .DW(17)) u_mem (
      .clk  (clk),
      .en   (mem_en),
      .we   (mem_we),
      .addr (mem_addr),
      .din  (mem_din),
      .dout (mem_dout)
   );

   // State register.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state <= S_CLR;
      end else begin
         state <= state_nx;
      end
   end

   // Next state: clearing sweep, accumulation until NPIX counted, then hold for readout.
   always_comb begin
      state_nx = state;
      if (h_clear) begin
         state_nx = S_CLR;
      end else begin
         case (state)
            S_CLR:   if (clr_addr == 8'd255) state_nx = S_ACC;
            S_ACC:   if (rmw_last) state_nx = S_RD;
            S_RD:    state_nx = S_RD;
            default: state_nx = S_CLR;
         endcase
      end
   end

   // Memory port owner is implied by state; h_clear suppresses every access.
   always_comb begin
      mem_en   = 1'b0;
      mem_we   = 1'b0;
      mem_addr = 8'd0;
      mem_din  = 17'd0;
      if (!h_clear) begin
         case (state)
            S_CLR: begin
               mem_en   = 1'b1;
               mem_we   = 1'b1;
               mem_addr = clr_addr;
            end
            S_ACC: begin
               if (rmw_stage == RMW_READ) begin
                  mem_en   = 1'b1;
                  mem_addr = rmw_bin;
               end else if (rmw_stage == RMW_WRITE) begin
                  mem_en   = 1'b1;
                  mem_we   = 1'b1;
                  mem_addr = rmw_bin;
                  mem_din  = mem_dout + 17'd1;
               end
            end
            S_RD: begin
               if (r_req) begin
                  mem_en   = 1'b1;
                  mem_addr = r_bin;
               end
            end
            default: mem_en = 1'b0;
         endcase
      end
   end

   // Clear sweep address, RMW pipeline, pixel count, status flags and readout pipe.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         clr_addr  <= 8'd0;
         pix_cnt   <= 17'd0;
         rmw_stage <= RMW_IDLE;
         rmw_bin   <= 8'd0;
         rd_pend   <= 1'b0;
         r_valid   <= 1'b0;
         r_data    <= 17'd0;
         o_done    <= 1'b0;
         o_drop    <= 1'b0;
      end else if (h_clear) begin
         clr_addr  <= 8'd0;
         pix_cnt   <= 17'd0;
         rmw_stage <= RMW_IDLE;
         rd_pend   <= 1'b0;
         r_valid   <= 1'b0;
         o_done    <= 1'b0;
         o_drop    <= 1'b0;
      end else begin
         if (state == S_CLR) begin
            clr_addr <= clr_addr + 8'd1;
            if (clr_addr == 8'd255) begin
               pix_cnt <= 17'd0;
            end
         end

         case (rmw_stage)
            RMW_IDLE: begin
               if (strb_take) begin
                  rmw_bin   <= i_data;
                  rmw_stage <= RMW_READ;
               end
            end
            RMW_READ:  rmw_stage <= RMW_WRITE;
            RMW_WRITE: begin
               rmw_stage <= RMW_IDLE;
               pix_cnt   <= pix_cnt + 17'd1;
            end
            default:   rmw_stage <= RMW_IDLE;
         endcase

         o_done <= rmw_last;
         if (strb_drop) begin
            o_drop <= 1'b1;
         end

         rd_pend <= rd_take;
         r_valid <= rd_pend;
         if (rd_pend) begin
            r_data <= mem_dout;
         end
      end
   end

endmodule

// File: tb/tb_filter2d_hist.sv
// tb/tb_filter2d_hist.sv - self-checking bench for filter2d_hist
module tb_filter2d_hist;

   localparam int NPIX = 512;

   logic        clk = 1'b0;
   logic        n_reset;
   logic        i_strb;
   logic [7:0]  i_data;
   logic        h_clear;
   logic        r_req;
   logic [7:0]  r_bin;
   logic        r_valid;
   logic [16:0] r_data;
   logic        o_ready;
   logic        o_done;
   logic        o_drop;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // reference model: bin counts plus the acceptance rules for strobes
   int hist [256];
   int cnt;
   bit m_acc;
   int last_acc;
   bit m_drop;
   int exp_done;
   int d0;

   int done_seen = 0;
   int done_cyc = -1;
   logic done_ready = 1'b1;

   always #5 clk = ~clk;

   filter2d_hist #(.NPIX(NPIX)) dut (
      .clk     (clk),
      .n_reset (n_reset),
      .i_strb  (i_strb),
      .i_data  (i_data),
      .h_clear (h_clear),
      .r_req   (r_req),
      .r_bin   (r_bin),
      .r_valid (r_valid),
      .r_data  (r_data),
      .o_ready (o_ready),
      .o_done  (o_done),
      .o_drop  (o_drop)
   );

   // record when the completion pulse appears and whether o_ready already fell
   always @(negedge clk) begin
      if (o_done === 1'b1) begin
         done_seen  = done_seen + 1;
         done_cyc   = cyc;
         done_ready = o_ready;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic model_reset();
      foreach (hist[i]) hist[i] = 0;
      cnt      = 0;
      m_acc    = 1'b0;
      m_drop   = 1'b0;
      last_acc = -100;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      int vseen = 0;
      while (o_ready !== 1'b1 && n < 1000) begin
         tick();
         n++;
         if (r_valid === 1'b1) vseen++;
      end
      check(tag, n, 256);
      check({tag, "_no_rvalid"}, vseen, 0);
      m_acc = 1'b1;
   endtask

   task automatic do_clear(input string tag, input bit with_strb);
      h_clear = 1'b1;
      if (with_strb) begin
         i_strb = 1'b1;
         i_data = 8'd42;
      end
      tick();
      h_clear = 1'b0;
      i_strb  = 1'b0;
      model_reset();
      check({tag, "_ready_low"}, o_ready, 0);
      check({tag, "_drop_clr"}, o_drop, 0);
      wait_ready({tag, "_clr_len"});
   endtask

   task automatic drive_px(input logic [7:0] v, input int gap);
      i_strb = 1'b1;
      i_data = v;
      if (m_acc && (cyc - last_acc >= 3)) begin
         hist[v]++;
         cnt++;
         last_acc = cyc;
         if (cnt == NPIX) begin
            m_acc    = 1'b0;
            exp_done = cyc + 3;
         end
      end else begin
         m_drop = 1'b1;
      end
      tick();
      i_strb = 1'b0;
      repeat (gap - 1) tick();
   endtask

   task automatic end_frame(input string tag);
      repeat (4) tick();
      check({tag, "_done_cnt"}, done_seen - d0, 1);
      check({tag, "_done_cyc"}, done_cyc, exp_done);
      check({tag, "_ready_at_done"}, done_ready, 0);
      check({tag, "_ready_after"}, o_ready, 0);
      check({tag, "_drop"}, o_drop, m_drop);
   endtask

   task automatic read_one(input string tag, input logic [7:0] b, input int exp);
      r_req = 1'b1;
      r_bin = b;
      tick();
      r_req = 1'b0;
      check({tag, "_lat1"}, r_valid, 0);
      tick();
      check({tag, "_valid"}, r_valid, 1);
      check({tag, "_data"}, r_data, exp);
      tick();
      check({tag, "_pulse"}, r_valid, 0);
   endtask

   task automatic read_all(input string tag);
      for (int i = 0; i <= 256; i++) begin
         if (i < 256) begin
            r_req = 1'b1;
            r_bin = 8'(i);
         end else begin
            r_req = 1'b0;
         end
         tick();
         if (i == 0) begin
            check({tag, "_first"}, r_valid, 0);
         end else begin
            check($sformatf("%s_v%0d", tag, i - 1), r_valid, 1);
            check($sformatf("%s_bin%0d", tag, i - 1), r_data, hist[i-1]);
         end
      end
      tick();
      check({tag, "_end"}, r_valid, 0);
      check({tag, "_hold"}, r_data, hist[255]);
   endtask

   initial begin
      n_reset = 1'b0;
      i_strb  = 1'b0;
      i_data  = 8'd0;
      h_clear = 1'b0;
      r_req   = 1'b0;
      r_bin   = 8'd0;
      repeat (3) tick();

      check("rst_r_valid", r_valid, 0);
      check("rst_r_data", r_data, 0);
      check("rst_o_ready", o_ready, 0);
      check("rst_o_done", o_done, 0);
      check("rst_o_drop", o_drop, 0);

      n_reset = 1'b1;
      model_reset();
      wait_ready("rst_clr_len");

      // readout request while accumulating is ignored
      r_req = 1'b1;
      r_bin = 8'd0;
      repeat (3) begin
         tick();
         check("acc_rreq_ignored", r_valid, 0);
      end
      r_req = 1'b0;
      check("acc_rdata_unch", r_data, 0);

      // constant-value frame at spacing 7
      d0 = done_seen;
      for (int k = 0; k < NPIX; k++) drive_px(8'h80, 7);
      end_frame("f80");
      read_one("f80_b80", 8'h80, NPIX);
      read_one("f80_b00", 8'h00, 0);
      check("f80_nodrop", o_drop, 0);

      // strobe in RD is dropped
      drive_px(8'd1, 2);
      check("rd_strb_drop", o_drop, 1);

      // ramp at the minimum spacing
      do_clear("ramp", 1'b0);
      d0 = done_seen;
      for (int k = 0; k < NPIX; k++) drive_px(8'(k % 256), 3);
      end_frame("ramp");
      read_all("ramp");

      // strobe inside the RMW window is dropped, frame needs NPIX valid pixels
      do_clear("drop", 1'b0);
      d0 = done_seen;
      drive_px(8'd5, 2);
      drive_px(8'd6, 3);
      check("drop_flag", o_drop, 1);
      for (int n = 0; n < 20000 && m_acc; n++) drive_px(8'd5, 3);
      end_frame("drop");
      read_one("drop_b5", 8'd5, NPIX);
      read_one("drop_b6", 8'd6, 0);

      // clear in the middle of accumulation, coincident strobe, readout attempts in CLR
      do_clear("mid", 1'b0);
      for (int k = 0; k < 100; k++) drive_px(8'd9, 4);
      r_req = 1'b1;
      do_clear("mid2", 1'b1);
      r_req = 1'b0;
      d0 = done_seen;
      for (int k = 0; k < NPIX; k++) drive_px(8'd1, 5);
      end_frame("mid");
      read_one("mid_b9", 8'd9, 0);
      read_one("mid_b1", 8'd1, NPIX);
      check("mid_nodrop", o_drop, 0);

      // randomized values and spacing, some below the RMW occupancy
      do_clear("rnd", 1'b0);
      d0 = done_seen;
      for (int n = 0; n < 20000 && m_acc; n++)
         drive_px(8'($urandom_range(255)), int'($urandom_range(6, 1)));
      end_frame("rnd");
      read_all("rnd");

      // reset asserted during the read cycle of an RMW
      do_clear("mrst", 1'b0);
      drive_px(8'd7, 1);
      drive_px(8'd7, 2);
      check("mrst_pre_drop", o_drop, 1);
      i_strb = 1'b1;
      i_data = 8'd7;
      tick();
      i_strb  = 1'b0;
      n_reset = 1'b0;
      #1;
      check("mrst_r_valid", r_valid, 0);
      check("mrst_r_data", r_data, 0);
      check("mrst_o_ready", o_ready, 0);
      check("mrst_o_done", o_done, 0);
      check("mrst_o_drop", o_drop, 0);
      repeat (2) tick();
      n_reset = 1'b1;
      model_reset();
      wait_ready("mrst_clr_len");
      d0 = done_seen;
      for (int k = 0; k < NPIX; k++) drive_px(8'd3, 3);
      end_frame("mrst");
      read_all("mrst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
